sha256_hash_state: RTL and testbench

SHA256_HASH_STATE -- requirements
Module: sha256_hash_state

---
 rtl/sha256_pkg.sv | 25 ++
 rtl/sha256_hash_word.sv | 40 ++++
 rtl/sha256_hash_state.sv | 126 ++++++++++++
 tb/tb_sha256_hash_state.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions: the 32-bit word type, the word count of the hash
// state, the initial hash value (IV) H0..H7 and a modulo-2^32 adder. Used by
// the hash-state logic and the round logic alike.
// No ports (package).
// -----------------------------------------------------------------------------
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int NUM_WORDS = 8;

   // Element [0] is H0, element [7] is H7.
   localparam logic [NUM_WORDS-1:0][31:0] SHA256_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   // SHA-256 additions drop the carry out; the 32-bit return type does that.
   function automatic word_t add32(input word_t x, input word_t y);
      return x + y;
   endfunction

endpackage

// File: rtl/sha256_hash_word.sv
// -----------------------------------------------------------------------------
// sha256_hash_word
// One word of the SHA-256 hash state: a chaining register holding H_i, the
// digest adder H_i + working variable, and the digest register.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   load   in   block transition: capture digest, reload chaining value
//   work   in   working variable (a..h) at round completion
//   chain  out  chaining value H_i of the block being processed
//   digest out  H_i + work captured at the last transition
// -----------------------------------------------------------------------------
module sha256_hash_word
   import sha256_pkg::*;
#(
   parameter word_t IV = '0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  word_t work,
   output word_t chain,
   output word_t digest
);

   // Every block is an independent single-block hash, so the chaining value
   // reloads the IV at a transition rather than taking the new digest.
   // NOTE: state registers use non-blocking assignments so that digest
   // samples the pre-edge chain value even though both update on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain  <= IV;
         digest <= '0;
      end else if (load) begin
         chain  <= IV;
         digest <= add32(chain, work);
      end
   end

endmodule

// File: rtl/sha256_hash_state.sv
// -----------------------------------------------------------------------------
// sha256_hash_state
// SHA-256 hash state for a double-hash datapath. Detects the end of each
// block from a change of the controller's block index, captures the digest
// (chaining value + final working variables) and pulses dvalid for one cycle.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   block[1:0]     in   block index; any change ends the previous block
//   a_in..h_in     in   working variables a..h at round completion
//   h1..h8         out  chaining value H0..H7 (registered)
//   h11..h18       out  round-0 load values for a..h (same as h1..h8)
//   d1..d8         out  digest of the last completed block
//   dvalid         out  one-cycle pulse, aligned with a new d1..d8
// -----------------------------------------------------------------------------
module sha256_hash_state
   import sha256_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] block,
   input  word_t      a_in,
   input  word_t      b_in,
   input  word_t      c_in,
   input  word_t      d_in,
   input  word_t      e_in,
   input  word_t      f_in,
   input  word_t      g_in,
   input  word_t      h_in,
   output word_t      h1,
   output word_t      h2,
   output word_t      h3,
   output word_t      h4,
   output word_t      h5,
   output word_t      h6,
   output word_t      h7,
   output word_t      h8,
   output word_t      h11,
   output word_t      h12,
   output word_t      h13,
   output word_t      h14,
   output word_t      h15,
   output word_t      h16,
   output word_t      h17,
   output word_t      h18,
   output word_t      d1,
   output word_t      d2,
   output word_t      d3,
   output word_t      d4,
   output word_t      d5,
   output word_t      d6,
   output word_t      d7,
   output word_t      d8,
   output logic       dvalid
);

   logic [1:0] prev_block;
   logic       transition;
   word_t      work   [NUM_WORDS];
   word_t      chain  [NUM_WORDS];
   word_t      digest [NUM_WORDS];

   // Any inequality counts, so jumps and the 3->0 wrap are transitions too.
   assign transition = (block != prev_block);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_block <= '0;
         dvalid     <= 1'b0;
      end else begin
         prev_block <= block;
         dvalid     <= transition;
      end
   end

   assign work[0] = a_in;
   assign work[1] = b_in;
   assign work[2] = c_in;
   assign work[3] = d_in;
   assign work[4] = e_in;
   assign work[5] = f_in;
   assign work[6] = g_in;
   assign work[7] = h_in;

   for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
      sha256_hash_word #(
         .IV (SHA256_IV[i])
      ) u_word (
         .clk    (clk),
         .rst    (rst),
         .load   (transition),
         .work   (work[i]),
         .chain  (chain[i]),
         .digest (digest[i])
      );
   end

   assign h1 = chain[0];
   assign h2 = chain[1];
   assign h3 = chain[2];
   assign h4 = chain[3];
   assign h5 = chain[4];
   assign h6 = chain[5];
   assign h7 = chain[6];
   assign h8 = chain[7];

   // The working registers load straight from the chaining registers.
   assign h11 = chain[0];
   assign h12 = chain[1];
   assign h13 = chain[2];
   assign h14 = chain[3];
   assign h15 = chain[4];
   assign h16 = chain[5];
   assign h17 = chain[6];
   assign h18 = chain[7];

   assign d1 = digest[0];
   assign d2 = digest[1];
   assign d3 = digest[2];
   assign d4 = digest[3];
   assign d5 = digest[4];
   assign d6 = digest[5];
   assign d7 = digest[6];
   assign d8 = digest[7];

endmodule

// File: tb/tb_sha256_hash_state.sv
// -----------------------------------------------------------------------------
// tb_sha256_hash_state
// Self-checking bench for sha256_hash_state. Expected digests are pushed to a
// scoreboard queue when a block transition is driven and popped when the
// edge that ends that cycle has passed.
// -----------------------------------------------------------------------------
module tb_sha256_hash_state;
   import sha256_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] block;
   word_t      a_in, b_in, c_in, d_in, e_in, f_in, g_in, h_in;
   word_t      h1, h2, h3, h4, h5, h6, h7, h8;
   word_t      h11, h12, h13, h14, h15, h16, h17, h18;
   word_t      d1, d2, d3, d4, d5, d6, d7, d8;
   logic       dvalid;

   sha256_hash_state dut (
      .clk    (clk),
      .rst    (rst),
      .block  (block),
      .a_in   (a_in),
      .b_in   (b_in),
      .c_in   (c_in),
      .d_in   (d_in),
      .e_in   (e_in),
      .f_in   (f_in),
      .g_in   (g_in),
      .h_in   (h_in),
      .h1     (h1),
      .h2     (h2),
      .h3     (h3),
      .h4     (h4),
      .h5     (h5),
      .h6     (h6),
      .h7     (h7),
      .h8     (h8),
      .h11    (h11),
      .h12    (h12),
      .h13    (h13),
      .h14    (h14),
      .h15    (h15),
      .h16    (h16),
      .h17    (h17),
      .h18    (h18),
      .d1     (d1),
      .d2     (d2),
      .d3     (d3),
      .d4     (d4),
      .d5     (d5),
      .d6     (d6),
      .d7     (d7),
      .d8     (d8),
      .dvalid (dvalid)
   );

   always #5 clk = ~clk;

   // SHA-256("abc") digest.
   localparam word_t ABC_DIGEST [NUM_WORDS] = '{
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
   };

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [255:0] sb_q [$];
   logic [1:0]   m_prev;
   logic [255:0] m_d;
   logic [255:0] iv_all;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pack8(input word_t w [NUM_WORDS]);
      logic [255:0] r;
      for (int i = 0; i < NUM_WORDS; i++) r[255-32*i -: 32] = w[i];
      return r;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_h"}, {h1, h2, h3, h4, h5, h6, h7, h8}, iv_all);
      check({tag, "_h1x"}, {h11, h12, h13, h14, h15, h16, h17, h18}, iv_all);
      check({tag, "_d"}, {d1, d2, d3, d4, d5, d6, d7, d8}, m_d);
   endtask

   task automatic set_work(input word_t x [NUM_WORDS]);
      a_in = x[0]; b_in = x[1]; c_in = x[2]; d_in = x[3];
      e_in = x[4]; f_in = x[5]; g_in = x[6]; h_in = x[7];
   endtask

   // Drives one cycle; outputs are sampled 1 time unit after the edge.
   task automatic drive_cycle(input string tag, input logic [1:0] blk,
                              input word_t x [NUM_WORDS]);
      logic [255:0] e;
      word_t        s;
      bit           tr;
      set_work(x);
      block = blk;
      tr = (blk != m_prev);
      if (tr) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            s = SHA256_IV[i] + x[i];
            e[255-32*i -: 32] = s;
         end
         sb_q.push_back(e);
      end
      m_prev = blk;
      @(posedge clk);
      #1;
      check({tag, "_dvalid"}, {255'd0, dvalid}, {255'd0, tr});
      if (tr && sb_q.size() > 0) m_d = sb_q.pop_front();
      check_state(tag);
   endtask

   function automatic void rand_work(output word_t x [NUM_WORDS]);
      for (int i = 0; i < NUM_WORDS; i++) x[i] = $urandom;
   endfunction

   initial begin
      word_t x [NUM_WORDS];

      for (int i = 0; i < NUM_WORDS; i++) iv_all[255-32*i -: 32] = SHA256_IV[i];
      for (int i = 0; i < NUM_WORDS; i++) x[i] = '0;

      // Reset: outputs must show the IV and zero digest right away.
      rst   = 1'b1;
      block = 2'd0;
      set_work(x);
      m_d    = '0;
      m_prev = 2'd0;
      #1;
      check("rst_now_dvalid", {255'd0, dvalid}, 256'd0);
      check_state("rst_now");
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold_dvalid", {255'd0, dvalid}, 256'd0);
         check_state("rst_hold");
      end
      rst = 1'b0;

      // Single block: 65 cycles on block 0, then the "abc" working variables.
      for (int c = 0; c < 65; c++) drive_cycle("blk0", 2'd0, x);
      for (int i = 0; i < NUM_WORDS; i++) x[i] = ABC_DIGEST[i] - SHA256_IV[i];
      drive_cycle("abc", 2'd1, x);
      check("abc_digest", {d1, d2, d3, d4, d5, d6, d7, d8}, pack8(ABC_DIGEST));
      rand_work(x);
      drive_cycle("abc_after", 2'd1, x);

      // 32-bit wrap of the digest adder.
      for (int i = 0; i < NUM_WORDS; i++) x[i] = '0;
      x[0] = 32'hffffffff;
      drive_cycle("wrap", 2'd2, x);
      check("wrap_d1", {224'd0, d1}, {224'd0, 32'h6a09e666});
      drive_cycle("wrap_after", 2'd2, x);

      // Step to 3, then wrap 3->0, then jump 0->2.
      rand_work(x);
      drive_cycle("to3", 2'd3, x);
      drive_cycle("at3", 2'd3, x);
      rand_work(x);
      drive_cycle("wrap30", 2'd0, x);
      drive_cycle("wrap30_after", 2'd0, x);
      rand_work(x);
      drive_cycle("jump02", 2'd2, x);
      drive_cycle("jump02_after", 2'd2, x);

      // Hold: block stable, working variables toggling.
      for (int c = 0; c < 200; c++) begin
         rand_work(x);
         drive_cycle("hold", 2'd2, x);
      end

      // Reset asserted together with a transition (2 -> 3).
      rand_work(x);
      set_work(x);
      block = 2'd3;
      rst   = 1'b1;
      m_d   = '0;
      #1;
      check("simrst_now_dvalid", {255'd0, dvalid}, 256'd0);
      check_state("simrst_now");
      @(posedge clk);
      #1;
      check("simrst_edge_dvalid", {255'd0, dvalid}, 256'd0);
      check_state("simrst_edge");
      rst = 1'b0;
      sb_q.delete();
      m_prev = 2'd0;

      // After release, block=3 differs from the reset prev_block of 0.
      rand_work(x);
      drive_cycle("post_rst", 2'd3, x);
      drive_cycle("post_rst_after", 2'd3, x);

      check("sb_empty", 256'(sb_q.size()), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
